// File: rtl/win3x3_gen_pkg.sv
// win3x3_gen_pkg: shared word width, default geometry, counter sizing and window type
package win3x3_gen_pkg;
  localparam int DW = 16;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  typedef logic [0:8][DW-1:0] win_t;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int CW_DEF = cnt_w(IMG_W_DEF);
  localparam int RW_DEF = cnt_w(IMG_H_DEF);
endpackage

// File: rtl/win3x3_gen_if.sv
// win3x3_gen_if: pixel-in / window-out valid-ready stream bundle
interface win3x3_gen_if import win3x3_gen_pkg::*;;
  logic s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic m_valid, m_ready, m_last;
  logic [DW-1:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;
  modport master(output s_valid, s_data, m_ready,
                 input s_ready, m_valid, m_last, d1, d2, d3, d4, d5, d6, d7, d8, d9);
  modport slave(input s_valid, s_data, m_ready,
                output s_ready, m_valid, m_last, d1, d2, d3, d4, d5, d6, d7, d8, d9);
endinterface

// File: rtl/win3x3_gen_line_buf.sv
// win3x3_gen_line_buf: one-row pixel store, async read and sync write at one address (read-before-write)
module win3x3_gen_line_buf import win3x3_gen_pkg::*; #(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  assign o_rdata = r_mem[i_addr];
  // overwrite the column slot; the old value was already read this cycle
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/win3x3_gen.sv
// win3x3_gen: streaming 3x3 window generator; define WIN_STRIDE2_EN for stride-2 windows
module win3x3_gen import win3x3_gen_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input logic clk,
  input logic rst,
  win3x3_gen_if.slave s_if
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  win_t r_win, w_win, r_out;
  logic r_valid, r_last;
  logic [DW-1:0] w_lb0, w_lb1;
  logic w_acc, w_emit, w_last, w_step, w_col_end;
`ifdef WIN_STRIDE2_EN
  localparam int LAST_R = ((IMG_H - 1) / 2) * 2;
  localparam int LAST_C = ((IMG_W - 1) / 2) * 2;
  assign w_step = !r_row[0] && !r_col[0];
`else
  localparam int LAST_R = IMG_H - 1;
  localparam int LAST_C = IMG_W - 1;
  assign w_step = 1'b1;
`endif
  assign s_if.s_ready = !rst && (!r_valid || s_if.m_ready);
  assign w_acc = s_if.s_valid && s_if.s_ready;
  assign w_col_end = r_col == CW'(IMG_W - 1);
  assign w_emit = w_acc && w_step && r_row >= RW'(2) && r_col >= CW'(2);
  assign w_last = r_row == RW'(LAST_R) && r_col == CW'(LAST_C);
  win3x3_gen_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .i_we(w_acc), .i_addr(r_col), .i_wdata(s_if.s_data), .o_rdata(w_lb0));
  win3x3_gen_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .i_we(w_acc), .i_addr(r_col), .i_wdata(w_lb0), .o_rdata(w_lb1));
  // window after shifting left and appending the column {older row, previous row, new pixel}
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_win[3*k]   = r_win[3*k+1];
      w_win[3*k+1] = r_win[3*k+2];
    end
    w_win[2] = w_lb1;
    w_win[5] = w_lb0;
    w_win[8] = s_if.s_data;
  end
  // raster position and shift window advance only on an accepted pixel
  always_ff @(posedge clk)
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
    end else if (w_acc) begin
      r_win <= w_win;
      r_col <= w_col_end ? '0 : r_col + CW'(1);
      if (w_col_end) r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
    end
  // single output register: load on emit, hold under backpressure, clear once taken
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_out   <= '0;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_last  <= w_last;
      r_out   <= w_win;
    end else if (s_if.m_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  assign s_if.m_valid = r_valid;
  assign s_if.m_last  = r_last;
  assign s_if.d1 = r_out[0];
  assign s_if.d2 = r_out[1];
  assign s_if.d3 = r_out[2];
  assign s_if.d4 = r_out[3];
  assign s_if.d5 = r_out[4];
  assign s_if.d6 = r_out[5];
  assign s_if.d7 = r_out[6];
  assign s_if.d8 = r_out[7];
  assign s_if.d9 = r_out[8];
endmodule

// File: tb/tb_win3x3_gen.sv
// tb_win3x3_gen: random-stimulus bench with a 2-D image model of the expected window stream
module tb_win3x3_gen;
  import win3x3_gen_pkg::*;
  localparam int W = 5;
  localparam int H = 5;
`ifdef WIN_STRIDE2_EN
  localparam bit S2 = 1'b1;
`else
  localparam bit S2 = 1'b0;
`endif
  localparam int LR = S2 ? ((H - 1) / 2) * 2 : H - 1;
  localparam int LC = S2 ? ((W - 1) / 2) * 2 : W - 1;
  localparam int NW = S2 ? ((H - 1) / 2) * ((W - 1) / 2) : (H - 2) * (W - 2);
  typedef logic [9*DW-1:0] w9_t;
  typedef struct {
    w9_t  w;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  win3x3_gen_if bus();
  win3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .s_if(bus.slave));

  int total = 0;
  int bad = 0;
  exp_t q[$];
  int img[H][W];
  int mr = 0, mc = 0;
  logic acc = 1'b0, was_rst = 1'b0;
  logic [DW-1:0] acc_d = '0;
  w9_t logw[128];
  logic loglast[128];
  int nx = 0;
  w9_t prev_d = '0;
  logic prev_last = 1'b0, prev_stall = 1'b0;
  w9_t act;
  assign act = {bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6, bus.d7, bus.d8, bus.d9};

  function automatic void chk(input bit ok, input string nm, input w9_t a, input w9_t e);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endfunction

  function automatic w9_t lit(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4), DW'(a5), DW'(a6), DW'(a7), DW'(a8)};
  endfunction

  always @(posedge clk) begin
    acc     <= bus.s_valid && bus.s_ready && !rst;
    acc_d   <= bus.s_data;
    was_rst <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    bit em;
    em = 1'b0;
    if (was_rst) begin
      q.delete();
      mr = 0;
      mc = 0;
      chk(!bus.m_valid && !bus.m_last && act == '0, "reset_state", act, '0);
    end else if (acc) begin
      img[mr][mc] = int'(acc_d);
      if (mr >= 2 && mc >= 2 && (!S2 || (mr % 2 == 0 && mc % 2 == 0))) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[(8 - (3*i + j))*DW +: DW] = DW'(img[mr-2+i][mc-2+j]);
        e.last = (mr == LR && mc == LC);
        q.push_back(e);
        em = 1'b1;
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else mc++;
    end
    if (em) chk(bus.m_valid === 1'b1, "latency1_valid", w9_t'(bus.m_valid), w9_t'(1));
    chk(bus.s_ready === (rst ? 1'b0 : (!bus.m_valid || bus.m_ready)), "s_ready",
        w9_t'(bus.s_ready), w9_t'(rst ? 1'b0 : (!bus.m_valid || bus.m_ready)));
    if (prev_stall && !was_rst)
      chk(bus.m_valid && act == prev_d && bus.m_last == prev_last, "stall_hold", act, prev_d);
    if (bus.m_valid) begin
      if (q.size() == 0) chk(1'b0, "spurious_window", act, '0);
      else begin
        chk(act == q[0].w, "window_data", act, q[0].w);
        chk(bus.m_last == q[0].last, "window_last", w9_t'(bus.m_last), w9_t'(q[0].last));
        if (bus.m_ready && !rst) void'(q.pop_front());
      end
      if (bus.m_ready && !rst && nx < 128) begin
        logw[nx] = act;
        loglast[nx] = bus.m_last;
        nx++;
      end
    end
    prev_stall = bus.m_valid && !bus.m_ready && !rst;
    prev_d = act;
    prev_last = bus.m_last;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input int n, input int gap);
    int i = 0;
    int g = 0;
    while (i < n && g < 4000) begin
      bus.s_valid = ($urandom_range(0, 99) >= gap);
      bus.s_data = DW'(base + i);
      step();
      if (acc) i++;
      g++;
    end
    bus.s_valid = 1'b0;
    chk(i == n, "send_budget", w9_t'(i), w9_t'(n));
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic count_chk(input int s, input int n, input int nlast, input string nm);
    int nl = 0;
    for (int k = s; k < nx; k++) nl += int'(loglast[k]);
    chk(nx - s == n, nm, w9_t'(nx - s), w9_t'(n));
    chk(nl == nlast, "last_count", w9_t'(nl), w9_t'(nlast));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int s;
    int g;
    bit done;
    w9_t first_w, last_w, second_w;
    first_w  = lit(0, 1, 2, 5, 6, 7, 10, 11, 12);
    last_w   = lit(12, 13, 14, 17, 18, 19, 22, 23, 24);
    second_w = S2 ? lit(2, 3, 4, 7, 8, 9, 12, 13, 14) : lit(1, 2, 3, 6, 7, 8, 11, 12, 13);
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    // single frame, continuous input
    s = nx;
    send(0, 25, 0);
    drain(5);
    count_chk(s, NW, 1, "t1_count");
    chk(logw[s] == first_w && !loglast[s], "t1_first", logw[s], first_w);
    chk(logw[s+NW-1] == last_w && loglast[s+NW-1], "t1_last", logw[s+NW-1], last_w);
    // backpressure after the first window
    s = nx;
    g = 0;
    fork
      send(0, 25, 0);
      begin
        while (!bus.m_valid && g < 200) begin
          step();
          g++;
        end
        chk(g < 200, "t2_wait_first", w9_t'(g), w9_t'(200));
        bus.m_ready = 1'b0;
        repeat (10) begin
          step();
          chk(bus.s_ready == 1'b0 && bus.m_valid, "t2_stalled", w9_t'(bus.s_ready), '0);
        end
        bus.m_ready = 1'b1;
      end
    join
    drain(5);
    count_chk(s, NW, 1, "t2_count");
    chk(logw[s] == first_w, "t2_first", logw[s], first_w);
    chk(logw[s+1] == second_w, "t2_second", logw[s+1], second_w);
    // random input gaps with random downstream readiness
    s = nx;
    done = 1'b0;
    fork
      begin
        send(0, 25, 50);
        done = 1'b1;
      end
      while (!done) begin
        bus.m_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    join
    bus.m_ready = 1'b1;
    drain(10);
    count_chk(s, NW, 1, "t3_count");
    chk(logw[s] == first_w, "t3_first", logw[s], first_w);
    chk(logw[s+NW-1] == last_w, "t3_last", logw[s+NW-1], last_w);
    // two frames back to back
    s = nx;
    send(0, 25, 0);
    send(100, 25, 0);
    drain(5);
    count_chk(s, 2 * NW, 2, "t4_count");
    chk(logw[s+NW] == lit(100, 101, 102, 105, 106, 107, 110, 111, 112), "t4_f2_first",
        logw[s+NW], lit(100, 101, 102, 105, 106, 107, 110, 111, 112));
    // reset mid-frame, then a full frame
    send(0, 13, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    s = nx;
    send(0, 25, 0);
    drain(5);
    count_chk(s, NW, 1, "t5_count");
    chk(logw[s] == first_w, "t5_first", logw[s], first_w);
    chk(q.size() == 0, "queue_empty", w9_t'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
